seq_det_arbiter: RTL and testbench
==================================

# seq_det_arbiter

Round-robin scheduler that shares a single serial 1010 Moore overlapping sequence detector among NREQ byte-wide requesters. It accepts one request word at a time and clears the detector. It then shifts the word bit-serially into the detector's din, counts pattern pulses, and returns the per-word match count to the granted requester. It sits between the requester ports and the `seq_det` instance, which it drives through det_rst/det_din and observes through det_pattern.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, bits per request word (≥4)
- CW, $clog2(WIDTH)+1, match counter width
- clk  input  1  clock; all logic on posedge
- rst  input  1  synchronous, active-high reset
- req  input  NREQ  per-requester request; held until matching gnt bit
- req_data  input  NREQ*WIDTH  requester i word at [i*WIDTH +: WIDTH]
- gnt  output  NREQ  one-hot, one-cycle pulse: word accepted
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse: result valid
- done_id  output  $clog2(NREQ)  index of requester whose result is on match_cnt
- match_cnt  output  CW  number of 1010 detections in the word
- det_rst  output  1  detector reset
- det_din  output  1  detector serial input
- det_pattern  input  1  detector Moore output (state S4 decode)

## Operation
- Clock is clk. Reset rst is synchronous and active-high.
- States: IDLE, CLEAR, SHIFT, DRAIN, DONE.
- IDLE: if any req is high, arbitrate, latch the winner's word and index, and go to CLEAR. Otherwise stay in IDLE.
- CLEAR: gnt[id] is high and det_rst is high for 1 cycle. Clear the match counter and bit counter. Go to SHIFT.
- SHIFT: runs WIDTH cycles. det_din = the latched word bit, MSB first by default. The bit counter goes 0..WIDTH-1. After bit WIDTH-1, go to DRAIN.
- DRAIN: 1 cycle. det_din=0. This state captures the Moore detection caused by the final bit.
- DONE: done=1 for 1 cycle. match_cnt and done_id hold until the next DONE. In this cycle, arbitrate again: any req → CLEAR, otherwise → IDLE.
- Counting: in every SHIFT and DRAIN cycle with det_pattern=1, increment match_cnt. The count saturates at 2^CW-1.
- Because the detector is cleared every job, matches never span two words.
- Round-robin arbitration:
  - Priority starts at (last granted index + 1) mod NREQ.
  - After reset, requester 0 has highest priority.
  - The pointer advances only on a grant.
- A requester must hold req and req_data stable until it sees its gnt bit. The word is latched at the edge that enters CLEAR. A req still high after its gnt is treated as a new request.
- det_rst = rst OR (state==CLEAR).
- Reset behaviour:
  - While rst is high: state=IDLE, gnt=0, busy=0, done=0, done_id=0, match_cnt=0, det_din=0, det_rst=1, and the RR pointer selects requester 0.
  - rst asserted mid-job aborts the job with no done pulse. The aborted requester must re-request.

## Timing
- Req sampled high in IDLE at cycle t:
  - gnt and det_rst at t+1 (CLEAR)
  - bits on det_din at t+2..t+1+WIDTH
  - DRAIN at t+2+WIDTH
  - done at t+3+WIDTH
- Back-to-back throughput: one word per WIDTH+3 cycles. The next gnt occurs the cycle after DONE.
- det_pattern for bit k (presented in SHIFT cycle k) is sampled in cycle k+1. No detection is possible in SHIFT cycle 0, because the detector was reset in CLEAR.
- All outputs are registered except det_rst and det_din, which are decoded from registered state, counters and the latched word.

## Configuration
- SEQ_DET_LSB_FIRST_EN:
  - Defined: the word is shifted LSB first (bit 0 in SHIFT cycle 0).
  - Undefined (default): the word is shifted MSB first (bit WIDTH-1 in SHIFT cycle 0).
- No other behaviour changes.

## Test plan
- Reset then idle: rst for 2 cycles, then no req for 10 cycles → all outputs 0 except det_rst=1 during rst; busy stays 0.
- Single job, overlap: req[0]=1, word 8'hAA (MSB first) → gnt=4'b0001 at t+1, done at t+11, match_cnt=3, done_id=0.
- Final-bit detection and zero result: 8'hA0 → match_cnt=1. 8'h0A → match_cnt=1 (caught in DRAIN). 8'h00 → match_cnt=0.
- Round-robin and simultaneous requests: req=4'b0101 held → gnt order 0, 2, 0, 2, with each gnt spaced 11 cycles apart. Then req=4'b1111 after the last grant to 2 → gnt order 3, 0, 1, 2.
- Mid-job reset: assert rst during SHIFT cycle 4 → no done pulse, outputs at reset values. A re-issued req[1] with 8'hAA → match_cnt=3.
- Macro: word 8'h05 with SEQ_DET_LSB_FIRST_EN defined → match_cnt=1. Same word without the macro → match_cnt=0.

Source files
------------

// File: rtl/seq_det_arbiter_if.sv
// Requester-side bus of seq_det_arbiter: request/word inputs, grant and result outputs.
interface seq_det_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  localparam int CW  = $clog2(WIDTH) + 1;
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  done;
  logic [IDW-1:0]        done_id;
  logic [CW-1:0]         match_cnt;

  modport master (output req, req_data, input gnt, busy, done, done_id, match_cnt);
  modport slave  (input req, req_data, output gnt, busy, done, done_id, match_cnt);
endinterface

// File: rtl/seq_det_arbiter.sv
// Round-robin scheduler sharing one serial 1010 Moore detector among NREQ requesters.
// Optional macro SEQ_DET_LSB_FIRST_EN shifts words LSB first (default MSB first).
module seq_det_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  seq_det_arbiter_if.slave   bus,
  output logic               det_rst,
  output logic               det_din,
  input  logic               det_pattern
);
  localparam int CW  = $clog2(WIDTH) + 1;
  localparam int IDW = $clog2(NREQ);
  localparam int BW  = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, DONE} state_t;

  state_t           state, state_nxt;
  logic [IDW-1:0]   ptr, win_id, id_q, ptr_nxt;
  logic             win_vld, grant;
  logic [WIDTH-1:0] word_q;
  logic [BW-1:0]    bit_cnt, sel;
  logic [CW-1:0]    acc, match_cnt_q;
  logic [NREQ-1:0]  gnt_q;
  logic             busy_q, done_q;
  logic [IDW-1:0]   done_id_q;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c, input logic en);
    if (en && (c != {CW{1'b1}})) return c + CW'(1);
    return c;
  endfunction

  // Rotating priority: the lowest offset from ptr with a pending request wins.
  always_comb begin
    logic [IDW-1:0] cand;
    win_vld = 1'b0;
    win_id  = '0;
    cand    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IDW'((int'(ptr) + k) % NREQ);
      if (bus.req[cand]) begin
        win_vld = 1'b1;
        win_id  = cand;
      end
    end
  end

  assign grant   = ((state == IDLE) || (state == DONE)) && win_vld;
  assign ptr_nxt = IDW'((int'(win_id) + 1) % NREQ);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = CLEAR;
      CLEAR:   state_nxt = SHIFT;
      SHIFT:   if (bit_cnt == BW'(WIDTH - 1)) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = win_vld ? CLEAR : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      bit_cnt     <= '0;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      done_id_q   <= '0;
      match_cnt_q <= '0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt != IDLE);
      done_q <= (state_nxt == DONE);
      gnt_q  <= grant ? ({{(NREQ-1){1'b0}}, 1'b1} << win_id) : '0;
      if (grant) ptr <= ptr_nxt;
      if (state == CLEAR) bit_cnt <= '0;
      else if (state == SHIFT) bit_cnt <= bit_cnt + BW'(1);
      // The DRAIN sample carries the detection caused by the final bit.
      if (state == DRAIN) begin
        match_cnt_q <= sat_inc(acc, det_pattern);
        done_id_q   <= id_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (grant) begin
      word_q <= bus.req_data[win_id*WIDTH +: WIDTH];
      id_q   <= win_id;
    end
    if (state == CLEAR) acc <= '0;
    else if (state == SHIFT) acc <= sat_inc(acc, det_pattern);
  end

`ifdef SEQ_DET_LSB_FIRST_EN
  assign sel = bit_cnt;
`else
  assign sel = BW'(WIDTH - 1) - bit_cnt;
`endif

  assign det_din = (state == SHIFT) && word_q[sel];
  assign det_rst = rst || (state == CLEAR);

  assign bus.gnt       = gnt_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.done_id   = done_id_q;
  assign bus.match_cnt = match_cnt_q;
endmodule

// File: tb/tb_seq_det_arbiter.sv
// Directed bench for seq_det_arbiter with a behavioural 1010 Moore detector attached.
module tb_seq_det_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic det_rst, det_din, det_pattern;
  logic [2:0] dstate;

  int pass_cnt = 0;
  int total_cnt = 0;

  seq_det_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  seq_det_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .det_rst(det_rst), .det_din(det_din), .det_pattern(det_pattern)
  );

  always #5 clk = ~clk;

  // Overlapping 1010 Moore detector: S0..S4, output in S4.
  always @(posedge clk) begin
    if (det_rst) dstate <= 3'd0;
    else case (dstate)
      3'd0: dstate <= det_din ? 3'd1 : 3'd0;
      3'd1: dstate <= det_din ? 3'd1 : 3'd2;
      3'd2: dstate <= det_din ? 3'd3 : 3'd0;
      3'd3: dstate <= det_din ? 3'd1 : 3'd4;
      3'd4: dstate <= det_din ? 3'd3 : 3'd0;
      default: dstate <= 3'd0;
    endcase
  end
  assign det_pattern = (dstate == 3'd4);

  typedef struct {
    int         rid;
    logic [7:0] word;
    int         exp_msb;
    int         exp_lsb;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [7:0] ser_order(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
`ifdef SEQ_DET_LSB_FIRST_EN
      r[7-i] = w[i];
`else
      r[7-i] = w[7-i];
`endif
    end
    return r;
  endfunction

  task automatic run_job(input int rid, input logic [7:0] word, input int exp);
    int n;
    int m;
    logic [7:0] seen;
    @(negedge clk);
    bus.req_data[rid*WIDTH +: WIDTH] = word;
    bus.req[rid] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.gnt == '0 && n < 30);
    chk("gnt_latency", n, 1);
    chk("gnt_onehot", int'(bus.gnt), 1 << rid);
    chk("det_rst_clear", int'(det_rst), 1);
    bus.req[rid] = 1'b0;
    m = 0;
    seen = '0;
    do begin
      @(negedge clk);
      m++;
      if (m <= 8) seen[8-m] = det_din;
    end while (!bus.done && m < 40);
    chk("done_latency", m, 10);
    chk("din_order", int'(seen), int'(ser_order(word)));
    chk("match_cnt", int'(bus.match_cnt), exp);
    chk("done_id", int'(bus.done_id), rid);
    @(negedge clk);
    chk("done_pulse", int'(bus.done), 0);
    chk("idle_busy", int'(bus.busy), 0);
    chk("cnt_hold", int'(bus.match_cnt), exp);
  endtask

  initial begin
    int gid[8];
    int gcyc[8];
    int ng;
    int cyc;
    int done_seen;
    int n;

    bus.req = '0;
    bus.req_data = '0;

    vecs[0] = '{0, 8'hAA, 3, 2};
    vecs[1] = '{0, 8'hA0, 1, 0};
    vecs[2] = '{0, 8'h0A, 1, 1};
    vecs[3] = '{0, 8'h00, 0, 0};
    vecs[4] = '{1, 8'h05, 0, 1};
    vecs[5] = '{2, 8'h5A, 1, 1};
    vecs[6] = '{1, 8'hFF, 0, 0};
    vecs[7] = '{3, 8'hD4, 2, 1};

    // Reset, then idle.
    @(negedge clk);
    chk("rst_det_rst", int'(det_rst), 1);
    chk("rst_gnt", int'(bus.gnt), 0);
    chk("rst_busy", int'(bus.busy), 0);
    @(negedge clk);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_match", int'(bus.match_cnt), 0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.busy || bus.gnt != '0 || bus.done || det_rst || det_din)
        chk("idle_quiet", 1, 0);
    end
    chk("idle_busy", int'(bus.busy), 0);
    chk("idle_det_rst", int'(det_rst), 0);

    for (int v = 0; v < 8; v++) begin
`ifdef SEQ_DET_LSB_FIRST_EN
      run_job(vecs[v].rid, vecs[v].word, vecs[v].exp_lsb);
`else
      run_job(vecs[v].rid, vecs[v].word, vecs[v].exp_msb);
`endif
    end

    // Round-robin: 0101 held for four grants, then 1111 for four more.
    bus.req_data = {8'hD4, 8'h5A, 8'hFF, 8'hAA};
    @(negedge clk);
    bus.req = 4'b0101;
    ng = 0;
    cyc = 0;
    while (ng < 8 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus.gnt != '0) begin
        gid[ng]  = $clog2(int'(bus.gnt));
        gcyc[ng] = cyc;
        ng++;
        if (ng == 4) bus.req = 4'b1111;
        if (ng == 8) bus.req = 4'b0000;
      end
    end
    chk("rr_grants", ng, 8);
    chk("rr_g0", gid[0], 0);
    chk("rr_g1", gid[1], 2);
    chk("rr_g2", gid[2], 0);
    chk("rr_g3", gid[3], 2);
    chk("rr_g4", gid[4], 3);
    chk("rr_g5", gid[5], 0);
    chk("rr_g6", gid[6], 1);
    chk("rr_g7", gid[7], 2);
    for (int i = 1; i < 8; i++) chk("rr_spacing", gcyc[i] - gcyc[i-1], 11);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 40);
    chk("rr_last_latency", n, 10);
    chk("rr_last_id", int'(bus.done_id), 2);
`ifdef SEQ_DET_LSB_FIRST_EN
    chk("rr_last_cnt", int'(bus.match_cnt), 1);
`else
    chk("rr_last_cnt", int'(bus.match_cnt), 1);
`endif

    // Mid-job reset during SHIFT cycle 4.
    @(negedge clk);
    bus.req_data[1*WIDTH +: WIDTH] = 8'hAA;
    bus.req[1] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.gnt == '0 && n < 30);
    chk("mid_gnt", int'(bus.gnt), 2);
    bus.req[1] = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_busy_before", int'(bus.busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_done", int'(bus.done), 0);
    chk("mid_rst_match", int'(bus.match_cnt), 0);
    chk("mid_rst_id", int'(bus.done_id), 0);
    chk("mid_rst_det_rst", int'(det_rst), 1);
    chk("mid_rst_din", int'(det_din), 0);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) done_seen++;
    end
    chk("mid_no_done", done_seen, 0);
`ifdef SEQ_DET_LSB_FIRST_EN
    run_job(1, 8'hAA, 2);
`else
    run_job(1, 8'hAA, 3);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
